// File: rtl/space_invaders_pkg.sv
// Shared types and screen/sprite constants for the space invaders datapath blocks.
package space_invaders_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } missile_state_t;

  localparam int COORD_W          = 11;
  localparam int SCREEN_W         = 640;
  localparam int SCREEN_H         = 480;
  localparam int MISSILE_SPRITE_W = 4;
  localparam int MISSILE_SPRITE_H = 8;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RESET_VAL = 1 suppresses an edge for a level held through reset.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= RESET_VAL;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/player_missile_ctrl.sv
// Single player missile: launch on fire edge, climb once per frame, retire on hit/top, then reload cooldown.
module player_missile_ctrl
  import space_invaders_pkg::*;
#(
  parameter int X_OFFSET        = 16,
  parameter int MISSILE_H       = MISSILE_SPRITE_H,
  parameter int Y_SPEED         = 6,
  parameter int TOP_LIMIT       = 8,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               fire,
  input  logic [COORD_W-1:0] playerX,
  input  logic [COORD_W-1:0] playerY,
  input  logic               missileHit,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               missileActive,
  output logic               shotPulse
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  function automatic logic [COORD_W-1:0] sat_spawn_x(input logic [COORD_W-1:0] px);
    logic [COORD_W:0] sum;
    sum = {1'b0, px} + (COORD_W + 1)'(X_OFFSET);
    if (sum > (COORD_W + 1)'(SCREEN_W - 1)) return COORD_W'(SCREEN_W - 1);
    return sum[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] clamp_spawn_y(input logic [COORD_W-1:0] py);
    if ({1'b0, py} < (COORD_W + 1)'(MISSILE_H + TOP_LIMIT)) return COORD_W'(TOP_LIMIT);
    return py - COORD_W'(MISSILE_H);
  endfunction

  missile_state_t     state, next_state;
  logic [CNT_W-1:0]   cool_cnt;
  logic               fire_rise;
  logic               launch, retire, fly_step, cool_dec;

  rise_detect #(.RESET_VAL(1'b1)) u_fire_rise (
    .clk   (clk),
    .reset (reset),
    .d     (fire),
    .rise  (fire_rise)
  );

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    retire     = 1'b0;
    fly_step   = 1'b0;
    cool_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire_rise) begin
          launch     = 1'b1;
          next_state = FLYING;
        end
      end
      FLYING: begin
        // Hit wins over a coincident frame tick so the reported position stays where the hit occurred.
        if (missileHit) begin
          retire = 1'b1;
        end else if (startOfFrame) begin
          if (topLeftY < COORD_W'(TOP_LIMIT + Y_SPEED)) retire   = 1'b1;
          else                                          fly_step = 1'b1;
        end
        if (retire) next_state = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          cool_dec = 1'b1;
          if (cool_cnt <= CNT_W'(1)) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      topLeftX  <= '0;
      topLeftY  <= '0;
      shotPulse <= 1'b0;
      cool_cnt  <= '0;
    end else begin
      state     <= next_state;
      shotPulse <= launch;
      if (launch) begin
        topLeftX <= sat_spawn_x(playerX);
        topLeftY <= clamp_spawn_y(playerY);
      end else if (fly_step) begin
        topLeftY <= topLeftY - COORD_W'(Y_SPEED);
      end
      if (retire)        cool_cnt <= CNT_W'(COOLDOWN_FRAMES);
      else if (cool_dec) cool_cnt <= cool_cnt - CNT_W'(1);
    end
  end

  assign missileActive = (state == FLYING);

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Scoreboarded bench for player_missile_ctrl against a frame-level behavioural model.
module tb_player_missile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] playerX;
  logic [10:0] playerY;
  logic        missileHit;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        missileActive;
  logic        shotPulse;

  always #5 clk = ~clk;

  player_missile_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .fire          (fire),
    .playerX       (playerX),
    .playerY       (playerY),
    .missileHit    (missileHit),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .missileActive (missileActive),
    .shotPulse     (shotPulse)
  );

  typedef struct {
    int x;
    int y;
    bit act;
    bit shot;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: missile in flight or not, frames of reload left, position, last fire level.
  bit m_fly;
  int m_cool;
  int m_x, m_y;
  bit m_shot;
  bit m_prev_fire;

  int px_cur = 320;
  int py_cur = 450;

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model(input bit f, input bit s, input bit h, input int px, input int py, input bit r);
    bit rise;
    if (r) begin
      m_fly = 0; m_cool = 0; m_x = 0; m_y = 0; m_shot = 0; m_prev_fire = 1;
      return;
    end
    rise   = f && !m_prev_fire;
    m_shot = 0;
    if (m_fly) begin
      if (h) begin
        m_fly = 0; m_cool = 10;
      end else if (s) begin
        if (m_y < 8 + 6) begin
          m_fly = 0; m_cool = 10;
        end else begin
          m_y = m_y - 6;
        end
      end
    end else if (m_cool > 0) begin
      if (s) m_cool = m_cool - 1;
    end else if (rise) begin
      m_fly  = 1;
      m_shot = 1;
      m_x    = (px + 16 > 639) ? 639 : px + 16;
      m_y    = (py < 16) ? 8 : py - 8;
    end
    m_prev_fire = f;
  endtask

  task automatic step(input bit f, input bit s, input bit h, input int px, input int py, input bit r);
    exp_t e;
    fire         = f;
    startOfFrame = s;
    missileHit   = h;
    playerX      = 11'(px);
    playerY      = 11'(py);
    reset        = r;
    @(posedge clk);
    model(f, s, h, px, py, r);
    e.x = m_x; e.y = m_y; e.act = m_fly; e.shot = m_shot;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit f, input int per);
    for (int i = 0; i < n; i++)
      step(f, (per != 0) && (i % per == 0), 1'b0, px_cur, py_cur, 1'b0);
  endtask

  // Monitor: one expected record per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("topLeftX", int'(topLeftX), e.x);
        check("topLeftY", int'(topLeftY), e.y);
        check("missileActive", int'(missileActive), int'(e.act));
        check("shotPulse", int'(shotPulse), int'(e.shot));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit f_lvl;
    // Fire held through reset and afterwards must not launch.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, px_cur, py_cur, 1'b1);
    run(5, 1'b1, 0);
    // Release then press: launch at 336/442.
    step(1'b0, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    step(1'b1, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    run(2, 1'b0, 0);
    run(6, 1'b0, 2);
    // Full flight to the top with fire pulses ignored, into cooldown.
    for (int i = 0; i < 150; i++)
      step(i % 7 == 3, i % 2 == 0, 1'b0, px_cur, py_cur, 1'b0);
    // Key held across the cooldown end must not fire.
    run(40, 1'b1, 2);
    run(2, 1'b0, 0);

    // Hit coincident with a frame tick at Y = 400.
    py_cur = 408;
    step(1'b1, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    step(1'b0, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    step(1'b0, 1'b1, 1'b1, px_cur, py_cur, 1'b0);
    run(2, 1'b0, 0);
    run(24, 1'b0, 2);

    // Spawn saturation in X and clamp in Y.
    px_cur = 630; py_cur = 5;
    step(1'b1, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    step(1'b0, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    run(4, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, px_cur, py_cur, 1'b0);
    run(24, 1'b0, 2);

    // Reset mid-flight at Y = 200, then a normal launch.
    px_cur = 100; py_cur = 208;
    step(1'b1, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    step(1'b0, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    run(3, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, px_cur, py_cur, 1'b1);
    step(1'b0, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    step(1'b1, 1'b0, 1'b0, px_cur, py_cur, 1'b0);
    run(3, 1'b0, 0);

    // Randomised traffic.
    f_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) f_lvl = ~f_lvl;
      step(f_lvl, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
           int'($urandom_range(0, 700)), int'($urandom_range(0, 479)),
           $urandom_range(0, 399) == 0);
    end

    run(2, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_missile_ctrl.md
Name: player_missile_ctrl

Overview:
- Downstream consumer of the player movement stage. Takes the player sprite's top-left position and the fire key, and launches a single player missile.
- Each frame it moves the missile upward and retires it on a hit or at the top of the screen, then enforces a reload cooldown.
- Its outputs feed the missile sprite drawer, the collision logic and the sound block.

Parameters:
- X_OFFSET, 16: pixels added to playerX to centre the missile on the ship.
- MISSILE_H, 8: missile sprite height in pixels; spawn Y = playerY - MISSILE_H.
- Y_SPEED, 6: pixels moved upward per startOfFrame.
- TOP_LIMIT, 8: smallest legal topLeftY; the missile retires instead of going below this.
- COOLDOWN_FRAMES, 10: frames between missile retirement and the next allowed launch.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- startOfFrame  in  1  one-clk pulse at each frame start (30 Hz).
- fire  in  1  fire key level, already synchronised to clk.
- playerX  in  11  player topLeftX, in pixels.
- playerY  in  11  player topLeftY, in pixels.
- missileHit  in  1  one-clk pulse from collision logic: missile hit an invader or shield.
- topLeftX  out  11  missile top-left X, in pixels.
- topLeftY  out  11  missile top-left Y, in pixels.
- missileActive  out  1  missile in flight; this is the draw/collision enable.
- shotPulse  out  1  one-clk pulse on launch, for the sound block.

Behaviour:
- Reset (sampled on clk):
  - state = IDLE; topLeftX = 0; topLeftY = 0; missileActive = 0; shotPulse = 0; cooldown counter = 0.
  - fire_d = 1, so a key held through reset does not fire.
- Fire edge: fireRise = fire & ~fire_d, and fire_d <= fire every clk. Only a rising edge launches; a held key never auto-repeats.
- IDLE:
  - On fireRise: next clk state = FLYING, missileActive = 1, shotPulse = 1 for exactly that one clk.
  - topLeftX <= playerX + X_OFFSET, saturated at 639.
  - topLeftY <= playerY - MISSILE_H, clamped to TOP_LIMIT if playerY < MISSILE_H + TOP_LIMIT.
  - Launch latency is 1 clk from the fireRise cycle.
- FLYING:
  - topLeftX is frozen; it does not track the player.
  - On a clk with missileHit = 1: state = COOLDOWN, missileActive = 0 next clk. Hit has priority over a startOfFrame in the same clk.
  - Else on startOfFrame: if topLeftY < TOP_LIMIT + Y_SPEED, state = COOLDOWN and missileActive = 0. Otherwise topLeftY <= topLeftY - Y_SPEED. Subtraction never underflows.
  - fireRise while FLYING is ignored and not queued.
- COOLDOWN:
  - On entry the counter loads COOLDOWN_FRAMES.
  - Each startOfFrame decrements it by 1. When startOfFrame arrives with the counter at 1, or on entry with COOLDOWN_FRAMES = 0, state = IDLE.
  - fireRise is ignored; a key held across the cooldown end does not fire.
  - missileHit is ignored in IDLE and COOLDOWN.
- Outputs when inactive: topLeftX/Y hold their last values. Consumers must gate on missileActive.
- Reset mid-flight returns everything to reset values in the next clk.
- All arithmetic is unsigned 11-bit; intermediate sums are 12-bit for the saturation compare.

Decomposition:
- Shared package space_invaders_pkg holds:
  - state enum (IDLE, FLYING, COOLDOWN);
  - screen constants (SCREEN_W = 640, SCREEN_H = 480);
  - missile sprite dimensions.
- One sub-module: rise_detect (1-bit registered rising-edge detector with reset value parameter), reused for other key inputs.

Test Plan:
- Reset, playerX = 320, playerY = 450, fire pulse -> 1 clk later topLeftX = 336, topLeftY = 442, missileActive = 1, shotPulse high exactly 1 clk.
- Flight, no hit, COOLDOWN_FRAMES = 10:
  - After 3 startOfFrame: topLeftY = 424.
  - Retire on the frame where Y < 14, at Y = 10: missileActive = 0.
  - After 10 further frames: state IDLE.
- Hit: missileHit and startOfFrame in the same clk at Y = 400 -> missileActive = 0, topLeftY stays 400, no decrement.
- Fire held continuously from reset -> no launch. Release then press -> one launch. Fire pulses during FLYING and COOLDOWN -> no second shotPulse.
- Saturation: playerX = 630 -> topLeftX = 639. playerY = 5 -> topLeftY = 8.
- Reset asserted mid-flight at Y = 200 -> next clk all outputs 0, state IDLE. Fire rise after reset release -> normal launch.
